// File: rtl/mul_share_arb.sv
// mul_share_arb: one 16x16 multiplier shared among NUM_REQ requesters.
// A round-robin arbiter feeds a two-stage pipeline: operand register -> multiply -> product register.
// Each result is returned with the ID of the requester whose operands produced it.

// Combinational 16x16 multiplier, signed or unsigned selected per operation.
module int_mul_16by16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        sign,
   output logic [31:0] p
);
   logic signed [16:0] a_ext;
   logic signed [16:0] b_ext;
   logic signed [33:0] full;

   // One extra bit holds the sign or a zero, so a single signed multiplier covers both modes.
   assign a_ext = {sign & a[15], a};
   assign b_ext = {sign & b[15], b};
   assign full  = a_ext * b_ext;
   assign p     = full[31:0];
endmodule

module mul_share_arb #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [16*NUM_REQ-1:0] a_in,
   input  logic [16*NUM_REQ-1:0] b_in,
   input  logic [NUM_REQ-1:0]    sign_in,
   output logic [NUM_REQ-1:0]    gnt,
   output logic                  rsp_vld,
   output logic [ID_W-1:0]       rsp_id,
   output logic [31:0]           rsp_out,
   output logic                  busy
);
   logic [15:0]        a_lane [NUM_REQ];
   logic [15:0]        b_lane [NUM_REQ];

   logic [ID_W-1:0]    rr_ptr_reg;
   logic [ID_W-1:0]    rr_ptr_next;
   logic [NUM_REQ-1:0] gnt_raw;
   logic [ID_W-1:0]    gnt_idx;
   logic               gnt_found;
   logic [ID_W:0]      scan_idx;

   logic               s1_vld_reg;
   logic [15:0]        s1_a_reg;
   logic [15:0]        s1_b_reg;
   logic               s1_sign_reg;
   logic [ID_W-1:0]    s1_id_reg;
   logic [31:0]        mul_out;

   logic               rsp_vld_reg;
   logic [ID_W-1:0]    rsp_id_reg;
   logic [31:0]        rsp_out_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
         assign a_lane[gi] = a_in[16*gi +: 16];
         assign b_lane[gi] = b_in[16*gi +: 16];
      end
   endgenerate

   // Round-robin search: first requester at or above rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      gnt_raw   = '0;
      gnt_idx   = '0;
      gnt_found = 1'b0;
      scan_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
         if (scan_idx >= (ID_W+1)'(NUM_REQ))
            scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
         if (!gnt_found && req[scan_idx[ID_W-1:0]]) begin
            gnt_found                   = 1'b1;
            gnt_raw[scan_idx[ID_W-1:0]] = 1'b1;
            gnt_idx                     = scan_idx[ID_W-1:0];
         end
      end
   end

   // The pointer moves just past the winner; it holds when nobody is granted.
   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      if (gnt_found) begin
         if (gnt_idx == ID_W'(NUM_REQ-1))
            rr_ptr_next = '0;
         else
            rr_ptr_next = gnt_idx + ID_W'(1);
      end
   end

   // Grant is masked during reset so no requester believes its operands were taken.
   assign gnt = rst_n ? gnt_raw : '0;

   // Arbiter pointer and operand stage: capture the winner's operands at the grant edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_reg  <= '0;
         s1_vld_reg  <= 1'b0;
         s1_a_reg    <= '0;
         s1_b_reg    <= '0;
         s1_sign_reg <= 1'b0;
         s1_id_reg   <= '0;
      end else begin
         rr_ptr_reg <= rr_ptr_next;
         s1_vld_reg <= gnt_found;
         if (gnt_found) begin
            s1_a_reg    <= a_lane[gnt_idx];
            s1_b_reg    <= b_lane[gnt_idx];
            s1_sign_reg <= sign_in[gnt_idx];
            s1_id_reg   <= gnt_idx;
         end
      end
   end

   int_mul_16by16 u_mul (
      .a    (s1_a_reg),
      .b    (s1_b_reg),
      .sign (s1_sign_reg),
      .p    (mul_out)
   );

   // Product stage: data only updates with a valid op, so it holds when rsp_vld is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_vld_reg <= 1'b0;
         rsp_id_reg  <= '0;
         rsp_out_reg <= '0;
      end else begin
         rsp_vld_reg <= s1_vld_reg;
         if (s1_vld_reg) begin
            rsp_id_reg  <= s1_id_reg;
            rsp_out_reg <= mul_out;
         end
      end
   end

   assign rsp_vld = rsp_vld_reg;
   assign rsp_id  = rsp_id_reg;
   assign rsp_out = rsp_out_reg;
   assign busy    = s1_vld_reg | rsp_vld_reg;
endmodule

// File: tb/tb_mul_share_arb.sv
// Directed and randomized checks of the shared multiplier arbiter.
module tb_mul_share_arb;
   localparam int NR = 4;

   logic          clk;
   logic          rst_n;
   logic [NR-1:0] req;
   logic [63:0]   a_in;
   logic [63:0]   b_in;
   logic [NR-1:0] sign_in;
   logic [NR-1:0] gnt;
   logic          rsp_vld;
   logic [1:0]    rsp_id;
   logic [31:0]   rsp_out;
   logic          busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]  req;
      logic [15:0] a;
      logic [15:0] b;
      logic        sign;
      logic [3:0]  exp_gnt;
      logic [1:0]  exp_id;
      logic [31:0] exp_out;
   } vec_t;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] out;
   } rsp_t;

   vec_t vecs[8];
   rsp_t sb[$];

   mul_share_arb #(.NUM_REQ(NR)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .a_in    (a_in),
      .b_in    (b_in),
      .sign_in (sign_in),
      .gnt     (gnt),
      .rsp_vld (rsp_vld),
      .rsp_id  (rsp_id),
      .rsp_out (rsp_out),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input logic s);
      int          sa;
      int          sb_v;
      logic [31:0] ua;
      logic [31:0] ub;
      sa   = int'($signed(a));
      sb_v = int'($signed(b));
      ua   = {16'h0, a};
      ub   = {16'h0, b};
      return s ? 32'(sa * sb_v) : ua * ub;
   endfunction

   // Drive one requester's lane; other lanes get filler that must never reach the output.
   task automatic drive_one(input vec_t v);
      a_in    = {4{16'h5A5A}};
      b_in    = {4{16'hA5A5}};
      sign_in = {4{~v.sign}};
      for (int i = 0; i < NR; i++) begin
         if (v.req[i]) begin
            a_in[16*i +: 16] = v.a;
            b_in[16*i +: 16] = v.b;
            sign_in[i]       = v.sign;
         end
      end
      req = v.req;
   endtask

   initial begin
      logic [3:0]  exp_g;
      logic [3:0]  rnd_req;
      logic [1:0]  rr_model;
      logic        gp1;
      logic        gp2;
      logic [1:0]  w;
      logic        found;
      rsp_t        r;

      vecs[0] = '{4'b0001, 16'hFFFF, 16'hFFFF, 1'b0, 4'b0001, 2'd0, 32'hFFFE0001};
      vecs[1] = '{4'b0100, 16'h8000, 16'hFFFF, 1'b1, 4'b0100, 2'd2, 32'h00008000};
      vecs[2] = '{4'b0100, 16'hFFFD, 16'h0007, 1'b1, 4'b0100, 2'd2, 32'hFFFFFFEB};
      vecs[3] = '{4'b1000, 16'h8000, 16'h8000, 1'b1, 4'b1000, 2'd3, 32'h40000000};
      vecs[4] = '{4'b0010, 16'hFFFF, 16'h0002, 1'b0, 4'b0010, 2'd1, 32'h0001FFFE};
      vecs[5] = '{4'b0001, 16'hFFFF, 16'h0002, 1'b1, 4'b0001, 2'd0, 32'hFFFFFFFE};
      vecs[6] = '{4'b1000, 16'h7FFF, 16'h7FFF, 1'b1, 4'b1000, 2'd3, 32'h3FFF0001};
      vecs[7] = '{4'b0010, 16'h0000, 16'h1234, 1'b0, 4'b0010, 2'd1, 32'h00000000};

      // Reset with a request pending: grant must be masked.
      rst_n   = 1'b0;
      req     = 4'b0001;
      a_in    = '0;
      b_in    = '0;
      sign_in = '0;
      #1;
      chk("reset_gnt", 32'(gnt), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_rsp_vld", 32'(rsp_vld), 32'h0);
      chk("reset_rsp_out", rsp_out, 32'h0);
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // Fairness: all requesting for 8 cycles from rr_ptr=0.
      for (int i = 0; i < NR; i++) begin
         a_in[16*i +: 16] = 16'(i + 1);
         b_in[16*i +: 16] = 16'h0100;
      end
      sign_in = '0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         chk("fair_rsp_vld", 32'(rsp_vld), (c >= 2) ? 32'h1 : 32'h0);
         if (c >= 2) begin
            chk("fair_rsp_id", 32'(rsp_id), 32'((c - 2) % 4));
            chk("fair_rsp_out", rsp_out, 32'(((c - 2) % 4 + 1) * 256));
         end
         req = (c < 8) ? 4'b1111 : 4'b0000;
         #1;
         chk("fair_gnt", 32'(gnt), (c < 8) ? 32'(4'b0001 << (c % 4)) : 32'h0);
         $display("fair cycle %0d gnt=%b rsp_vld=%b rsp_id=%0d rsp_out=%h", c, gnt, rsp_vld, rsp_id, rsp_out);
      end

      // Table vectors: single requester per vector, 2-edge latency.
      @(posedge clk);
      #1;
      for (int v = 0; v < 8; v++) begin
         drive_one(vecs[v]);
         #1;
         chk("vec_gnt", 32'(gnt), 32'(vecs[v].exp_gnt));
         @(posedge clk);
         #1;
         req = '0;
         chk("vec_busy", 32'(busy), 32'h1);
         @(posedge clk);
         #1;
         chk("vec_rsp_vld", 32'(rsp_vld), 32'h1);
         chk("vec_rsp_id", 32'(rsp_id), 32'(vecs[v].exp_id));
         chk("vec_rsp_out", rsp_out, vecs[v].exp_out);
         $display("vec %0d req=%b a=%h b=%h s=%b -> id=%0d out=%h", v, vecs[v].req, vecs[v].a, vecs[v].b, vecs[v].sign, rsp_id, rsp_out);
      end
      @(posedge clk);
      #1;
      chk("vec_drain_vld", 32'(rsp_vld), 32'h0);
      chk("vec_drain_out_hold", rsp_out, vecs[7].exp_out);

      // Reset between grant edge and response edge.
      vecs[0] = '{4'b0010, 16'h1234, 16'h0003, 1'b0, 4'b0010, 2'd1, 32'h0};
      drive_one(vecs[0]);
      #1;
      chk("rst_pre_gnt", 32'(gnt), 32'b0010);
      @(posedge clk);
      #1;
      req = 4'b1010;
      #2;
      chk("rst_pre_busy", 32'(busy), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_busy", 32'(busy), 32'h0);
      chk("rst_async_vld", 32'(rsp_vld), 32'h0);
      chk("rst_async_gnt", 32'(gnt), 32'h0);
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         chk("rst_no_stale_vld", 32'(rsp_vld), 32'h0);
         chk("rst_no_stale_busy", 32'(busy), 32'h0);
      end
      req = 4'b1010;
      #1;
      chk("rst_rr0_gnt", 32'(gnt), 32'b0010);
      @(posedge clk);
      #1;
      chk("rst_rr2_gnt", 32'(gnt), 32'b1000);
      req = '0;
      $display("reset test done");

      // Idle: nothing granted, pipeline drains, pointer holds (it is 2 here).
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         chk("idle_gnt", 32'(gnt), 32'h0);
         if (c >= 1) begin
            chk("idle_vld", 32'(rsp_vld), 32'h0);
            chk("idle_busy", 32'(busy), 32'h0);
         end
      end
      req = 4'b1111;
      #1;
      chk("idle_rr_hold", 32'(gnt), 32'b0100);
      req = '0;
      $display("idle test done");

      // Random: reference arbiter and scoreboard in grant order.
      rr_model = 2'd2;
      gp1 = 1'b0;
      gp2 = 1'b0;
      for (int c = 0; c < 1002; c++) begin
         @(posedge clk);
         #1;
         chk("rnd_rsp_vld", 32'(rsp_vld), 32'(gp2));
         if (gp2 && sb.size() > 0) begin
            r = sb.pop_front();
            chk("rnd_rsp_id", 32'(rsp_id), 32'(r.id));
            chk("rnd_rsp_out", rsp_out, r.out);
         end
         rnd_req = (c < 1000) ? 4'($urandom_range(0, 15)) : 4'b0000;
         req     = rnd_req;
         a_in    = {$urandom, $urandom};
         b_in    = {$urandom, $urandom};
         sign_in = 4'($urandom_range(0, 15));
         exp_g   = '0;
         found   = 1'b0;
         for (int k = 0; k < NR; k++) begin
            w = rr_model + 2'(k);
            if (!found && rnd_req[w]) begin
               found    = 1'b1;
               exp_g[w] = 1'b1;
               sb.push_back('{w, ref_mul(a_in[16*w +: 16], b_in[16*w +: 16], sign_in[w])});
               rr_model = w + 2'd1;
            end
         end
         #1;
         chk("rnd_onehot", 32'($onehot0(gnt)), 32'h1);
         chk("rnd_gnt", 32'(gnt), 32'(exp_g));
         gp2 = gp1;
         gp1 = found;
      end
      chk("rnd_sb_empty", 32'(sb.size()), 32'h0);
      $display("random test done");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
